// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file and its dump engine.
package regfile_pkg;

    // Dump engine states: wait for a request, fetch one register, hold the beat until accepted.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } dump_state_t;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    // Architectural register that is hardwired to zero.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Debug-dump engine: walks every register index once and streams it out over a
// valid/ready handshake. The parent supplies the (bypassed) contents of rd_idx.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] rd_val,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              start_dump;
    logic              load_beat;
    logic              accept_beat;

    assign rd_idx = idx;

    // State register; reset aborts any dump in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a request only counts in IDLE, and SEND leaves only on an accepted beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (dump_start)  state_nxt = ST_LOAD;
            ST_LOAD:                  state_nxt = ST_SEND;
            ST_SEND: if (accept_beat) state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_LOAD;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: strobes that drive the index counter and beat registers.
    always_comb begin
        start_dump  = (state == ST_IDLE) && dump_start;
        load_beat   = (state == ST_LOAD);
        accept_beat = (state == ST_SEND) && dump_valid && dump_ready;
        dump_busy   = (state != ST_IDLE);
    end

    // Index counter and beat registers; the beat is frozen from LOAD until it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            if (start_dump) begin
                idx <= '0;
            end else if (accept_beat && (idx != LAST_IDX)) begin
                idx <= idx + ADDR_W'(1);
            end

            if (load_beat) begin
                dump_data  <= rd_val;
                dump_addr  <= idx;
                dump_valid <= 1'b1;
            end else if (accept_beat) begin
                dump_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD registered read ports with same-cycle write
// bypass, one write port, hardwired-zero r0, a watch comparator on one register,
// and a handshaked serial dump of the whole file.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int NUM_RD    = 2,
    parameter int WATCH_REG = 10,
    parameter int WATCH_VAL = 13,
    parameter int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     watch_hit,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data
);

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic                     wr_ok;
    logic [NUM_RD*DATA_W-1:0] rdata_nxt;
    logic                     watch_nxt;
    logic [ADDR_W-1:0]        dump_idx;
    logic [DATA_W-1:0]        dump_rd_val;

    // Addresses past the last register exist in the encoding when NUM_REGS is not a power of two.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // Value a reader sees at this edge: the incoming write wins, r0 and holes read as zero.
    function automatic logic [DATA_W-1:0] read_bypass(input logic [ADDR_W-1:0] a);
        if (wr_ok && (a == waddr)) return wdata;
        if ((a == ADDR_W'(REG_ZERO)) || !in_range(a)) return '0;
        return regs[a];
    endfunction

    assign wr_ok = wen && (waddr != ADDR_W'(REG_ZERO)) && in_range(waddr);

    // Register storage; r0 is never written so it stays zero.
    // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Per-port read mux with bypass; every port is independent.
    // NOTE: give every comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rdata_nxt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rdata_nxt[i*DATA_W +: DATA_W] = read_bypass(raddr[i*ADDR_W +: ADDR_W]);
        end
        watch_nxt   = (read_bypass(ADDR_W'(WATCH_REG)) == DATA_W'(WATCH_VAL));
        dump_rd_val = read_bypass(dump_idx);
    end

    // Registered read data and watch flag, both reflecting the post-write state.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata     <= '0;
            watch_hit <= 1'b0;
        end else begin
            rdata     <= rdata_nxt;
            watch_hit <= watch_nxt;
        end
    end

    regfile_dump_ctrl #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dump_ctrl (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .rd_idx     (dump_idx),
        .rd_val     (dump_rd_val),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param with default parameters.
module tb_regfile_param;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int ADDR_W   = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     wen;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     watch_hit;
    logic                     dump_start;
    logic                     dump_busy;
    logic                     dump_valid;
    logic                     dump_ready;
    logic [ADDR_W-1:0]        dump_addr;
    logic [DATA_W-1:0]        dump_data;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_regs [NUM_REGS];
    int          beats;
    int          cycles;

    regfile_param dut (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .rdata      (rdata),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .watch_hit  (watch_hit),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs driven 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        step();
        wen = 1'b0;
        if (a != 0) exp_regs[a] = d;
    endtask

    // Run one dump; toggle selects the 1-0-0-1 ready pattern plus a stray mid-dump start.
    task automatic run_dump(input string tag, input bit toggle, output int n_beats, output int n_cycles);
        logic [3:0] pat;
        pat      = 4'b1001;
        n_beats  = 0;
        n_cycles = 0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(dump_busy), 32'd1);
        while (dump_busy && n_cycles < 400) begin
            if (dump_valid) begin
                check({tag, "_addr"}, 32'(dump_addr), 32'(n_beats));
                check({tag, "_data"}, dump_data, exp_regs[n_beats % NUM_REGS]);
            end
            dump_ready = toggle ? pat[n_cycles % 4] : 1'b1;
            dump_start = toggle && (n_cycles == 9);
            if (dump_valid && dump_ready) n_beats++;
            step();
            n_cycles++;
        end
        dump_start = 1'b0;
        check({tag, "_idle_at_end"}, 32'(dump_busy), 32'd0);
        check({tag, "_valid_at_end"}, 32'(dump_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        raddr      = '0;
        wen        = 1'b0;
        waddr      = '0;
        wdata      = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state: every address reads zero on both ports.
        for (int a = 0; a < NUM_REGS; a++) begin
            raddr = {ADDR_W'(NUM_REGS - 1 - a), ADDR_W'(a)};
            step();
            check("rst_rd_p0", rdata[31:0], 32'h0);
            check("rst_rd_p1", rdata[63:32], 32'h0);
        end
        check("rst_watch", 32'(watch_hit), 32'd0);
        check("rst_busy", 32'(dump_busy), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_daddr", 32'(dump_addr), 32'd0);
        check("rst_ddata", dump_data, 32'h0);

        // Bypass on port 0 while port 1 reads r0.
        raddr = {5'd0, 5'd5};
        write_reg(5'd5, 32'hDEADBEEF);
        check("bypass_p0", rdata[31:0], 32'hDEADBEEF);
        check("bypass_p1_r0", rdata[63:32], 32'h0);

        // Write to r0 is dropped, even as a bypass.
        raddr = {5'd5, 5'd0};
        write_reg(5'd0, 32'h00001234);
        check("r0_bypass", rdata[31:0], 32'h0);
        check("r5_stored", rdata[63:32], 32'hDEADBEEF);
        step();
        check("r0_after", rdata[31:0], 32'h0);

        // Both ports on the same address during a write.
        raddr = {5'd7, 5'd7};
        write_reg(5'd7, 32'h0000A5A5);
        check("dual_bypass_p0", rdata[31:0], 32'h0000A5A5);
        check("dual_bypass_p1", rdata[63:32], 32'h0000A5A5);

        // Watch comparator on r10.
        check("watch_before", 32'(watch_hit), 32'd0);
        write_reg(5'd10, 32'd13);
        check("watch_rise", 32'(watch_hit), 32'd1);
        step();
        check("watch_hold", 32'(watch_hit), 32'd1);
        write_reg(5'd10, 32'd14);
        check("watch_fall", 32'(watch_hit), 32'd0);

        // Load rN = 3*N, then full dump with ready held high.
        for (int n = 1; n < NUM_REGS; n++) write_reg(ADDR_W'(n), 32'(n * 3));
        raddr = {5'd31, 5'd10};
        step();
        check("load_r10", rdata[31:0], 32'd30);
        check("load_r31", rdata[63:32], 32'd93);
        check("load_watch", 32'(watch_hit), 32'd0);

        run_dump("dump_fast", 1'b0, beats, cycles);
        check("dump_fast_beats", 32'(beats), 32'(NUM_REGS));
        check("dump_fast_cycles", 32'(cycles), 32'(2 * NUM_REGS));

        // Dump with ready 1-0-0-1 and a stray dump_start part way through.
        run_dump("dump_slow", 1'b1, beats, cycles);
        check("dump_slow_beats", 32'(beats), 32'(NUM_REGS));

        // Reset in the middle of beat 7.
        raddr      = {5'd10, 5'd5};
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        cycles = 0;
        while (!(dump_valid && dump_addr == 5'd7) && cycles < 100) begin
            step();
            cycles++;
        end
        dump_ready = 1'b0;
        check("beat7_reached", {26'd0, dump_valid, dump_addr}, {26'd0, 1'b1, 5'd7});
        check("beat7_data", dump_data, 32'd21);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(dump_valid), 32'd0);
        check("async_rst_busy", 32'(dump_busy), 32'd0);
        check("async_rst_daddr", 32'(dump_addr), 32'd0);
        check("async_rst_rdata", rdata[31:0], 32'h0);
        #2 reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
        step();
        check("post_rst_r5", rdata[31:0], 32'h0);
        check("post_rst_r10", rdata[63:32], 32'h0);
        check("post_rst_watch", 32'(watch_hit), 32'd0);

        run_dump("dump_restart", 1'b0, beats, cycles);
        check("dump_restart_beats", 32'(beats), 32'(NUM_REGS));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file, successor to the single-configuration 32×32 file in the processor datapath. It provides NUM_RD registered read ports with same-cycle write bypass, one write port, and a hardwired-zero register 0. It also provides a registered watch comparator for the test-result register and a handshaked debug-dump engine that streams every register out serially. It sits between decode (read addresses) and writeback (write port); the dump port feeds the board debug/UART logic.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (≥2; need not be a power of two)
- NUM_RD, 2, number of read ports
- WATCH_REG, 10, index compared by the watch logic
- WATCH_VAL, 13, value that raises watch_hit
- ADDR_W, $clog2(NUM_REGS), derived; not overridden

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, registered
- wen  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- watch_hit  out  1  registered: register WATCH_REG equals WATCH_VAL
- dump_start  in  1  one-cycle request to begin a dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts the beat
- dump_addr  out  ADDR_W  index of the current beat
- dump_data  out  DATA_W  contents of that register

## Operation
- Register 0 always reads 0. Writes to 0 are dropped.
- Writes to addresses ≥ NUM_REGS are dropped. Reads of such addresses return 0.
- Write: on a clock edge with wen=1, regs[waddr] <= wdata.
- Read port i: rdata_i <= regs[raddr_i], captured on the clock edge.
- Bypass: if wen=1, waddr=raddr_i, and waddr is not 0 (and is in range) in the same cycle, rdata_i captures wdata, the new value.
- All read ports are independent. Any number of ports may hit the same address or the bypass simultaneously.
- watch_hit <= (post-write value of regs[WATCH_REG] == WATCH_VAL). It rises the cycle after the qualifying write.
- Dump FSM states: IDLE, LOAD, SEND.
  - IDLE: dump_start=1 sets idx=0 and goes to LOAD. dump_start is ignored in LOAD and SEND.
  - LOAD: dump_data <= regs[idx] (bypass applies if a write to idx occurs this cycle), dump_addr <= idx, dump_valid <= 1, then go to SEND.
  - SEND: dump_valid stays high and data is held stable until dump_ready=1.
    - On accept with idx = NUM_REGS-1: dump_valid <= 0, go to IDLE.
    - On accept otherwise: idx++, dump_valid <= 0, go to LOAD.
- dump_busy = (state != IDLE).
- Normal reads and writes are fully independent of the dump; the dump never stalls them.
- A write to a register after its beat was loaded is not reflected in that beat.

## Timing
- Reset values: all registers 0, rdata 0, watch_hit 0, state IDLE, dump_valid 0, dump_addr 0, dump_data 0, dump_busy 0.
- Reset asserted mid-dump aborts the dump immediately, with dump_valid low asynchronously.
- Read latency: 1 cycle from address to rdata. Write-to-read visibility is 0 cycles via bypass.
- Dump cost: 2 cycles per beat minimum (LOAD + SEND) with dump_ready held high. A full dump therefore takes 2*NUM_REGS cycles from the dump_start edge to the return to IDLE.
- dump_ready is sampled only in SEND while dump_valid=1. dump_ready=1 at any other time has no effect.
- dump_start is accepted on the same edge the FSM returns to IDLE only from the following cycle onward.

## Structure
- Package regfile_pkg holds:
  - the dump state enum (IDLE/LOAD/SEND)
  - default DATA_W/NUM_REGS constants
  - the register-0 index constant
- Storage, write logic, read ports with bypass, and the watch comparator stay in regfile_param.
- Sub-module regfile_dump_ctrl contains the FSM, idx counter and handshake. It drives a dump read index and receives the read value from the parent.

## Test plan
- Reset, then read all addresses on both ports → every rdata is 0, watch_hit=0, dump_busy=0.
- Write 0xDEADBEEF to r5 while port 0 reads r5 and port 1 reads r0 in the same cycle → next cycle port 0 = 0xDEADBEEF (bypass), port 1 = 0. Then write 0x1234 to r0 → r0 still reads 0.
- Write 13 to r10 → watch_hit is 1 the following cycle. Write 14 → watch_hit drops one cycle later.
- Load rN=N*3 for all N, pulse dump_start, hold dump_ready=1 → NUM_REGS beats with addr 0..31 and data 0,3,…,93, completing in 64 cycles.
- Dump with dump_ready toggling 1-0-0-1 → each beat is held stable while not ready, no beat is skipped or duplicated, and a mid-dump dump_start is ignored.
- Assert reset during beat 7 → dump_valid and all registers go to 0 immediately. A fresh dump_start restarts at addr 0.
